// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a single-port write-first RAM between the core (C)
// and the host loader/debug master (H). Per-cycle round-robin with an optional
// host burst lock bounded by LOCK_MAX; routes 1-cycle read data to its owner.
// Optional grant/conflict statistics are compiled in with `define ARB_STATS_EN.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [3:0]            c_strobe,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [31:0]           c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [31:0]           c_rdata,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [3:0]            h_strobe,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [31:0]           h_wdata,
  input  logic                  h_lock,
  output logic                  h_gnt,
  output logic                  h_rvalid,
  output logic [31:0]           h_rdata,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_strobe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out,
  output logic [15:0]           stat_c_grants,
  output logic [15:0]           stat_h_grants,
  output logic [15:0]           stat_conflicts
);

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_H = 1'b1
  } port_t;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  port_t       last_gnt;
  logic [7:0]  lock_cnt;
  logic        rd_owner_valid;
  port_t       rd_owner;
  logic [31:0] c_rdata_q;
  logic [31:0] h_rdata_q;
  logic        rd_issue;

  // Grant decision: lock keeps the host only while it also won last cycle.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (reset_n) begin
      if (c_req && h_req) begin
        if (h_lock && (last_gnt == PORT_H) && (lock_cnt < LOCK_LIM)) begin
          h_gnt = 1'b1;
        end else if (last_gnt == PORT_H) begin
          c_gnt = 1'b1;
        end else begin
          h_gnt = 1'b1;
        end
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (h_req) begin
        h_gnt = 1'b1;
      end
    end
  end

  // RAM mux: idle cycles present the core address with writes disabled.
  always_comb begin
    ram_addr      = c_addr;
    ram_data_in   = c_wdata;
    ram_wr_strobe = 4'hF;
    ram_wr_en     = 1'b0;
    if (h_gnt) begin
      ram_addr      = h_addr;
      ram_data_in   = h_wdata;
      ram_wr_strobe = h_strobe;
      ram_wr_en     = h_we;
    end else if (c_gnt) begin
      ram_wr_strobe = c_strobe;
      ram_wr_en     = c_we;
    end
  end

  assign rd_issue = (c_gnt & ~c_we) | (h_gnt & ~h_we);

  // Read return is masked during reset so an in-flight read is dropped.
  assign c_rvalid = reset_n & rd_owner_valid & (rd_owner == PORT_C);
  assign h_rvalid = reset_n & rd_owner_valid & (rd_owner == PORT_H);
  assign c_rdata  = c_rvalid ? ram_data_out : c_rdata_q;
  assign h_rdata  = h_rvalid ? ram_data_out : h_rdata_q;

  // Arbitration history and host lock counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt <= PORT_H;
      lock_cnt <= '0;
    end else begin
      if (c_gnt) begin
        last_gnt <= PORT_C;
      end else if (h_gnt) begin
        last_gnt <= PORT_H;
      end
      if (!c_req || c_gnt) begin
        lock_cnt <= '0;
      end else if (h_gnt && (lock_cnt < LOCK_LIM)) begin
        lock_cnt <= lock_cnt + 8'd1;
      end
    end
  end

  // Read ownership tracking and per-port held read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_owner_valid <= 1'b0;
      rd_owner       <= PORT_C;
      c_rdata_q      <= '0;
      h_rdata_q      <= '0;
    end else begin
      rd_owner_valid <= rd_issue;
      if (rd_issue) begin
        rd_owner <= h_gnt ? PORT_H : PORT_C;
      end
      if (c_rvalid) begin
        c_rdata_q <= ram_data_out;
      end
      if (h_rvalid) begin
        h_rdata_q <= ram_data_out;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Free-running wrap-around statistics counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_c_grants  <= '0;
      stat_h_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (c_gnt) begin
        stat_c_grants <= stat_c_grants + 16'd1;
      end
      if (h_gnt) begin
        stat_h_grants <= stat_h_grants + 16'd1;
      end
      if (c_req && h_req) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
    end
  end
`else
  assign stat_c_grants  = '0;
  assign stat_h_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed steps with a read-return scoreboard against a
// behavioural write-first RAM. Stats checks follow `define ARB_STATS_EN.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 16;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  strobe;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } sb_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [3:0]    c_strobe;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata, c_rdata;
  logic          h_req, h_we, h_lock, h_gnt, h_rvalid;
  logic [3:0]    h_strobe;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_wdata, h_rdata;
  logic          ram_wr_en;
  logic [3:0]    ram_wr_strobe;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data_in, ram_data_out;
  logic [15:0]   stat_c_grants, stat_h_grants, stat_conflicts;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  sb_t         sb[$];
  logic [31:0] ref_mem [0:255];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .LOCK_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_strobe(c_strobe), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_strobe(h_strobe), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .h_rdata(h_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .stat_c_grants(stat_c_grants), .stat_h_grants(stat_h_grants),
    .stat_conflicts(stat_conflicts)
  );

  // Behavioural single-port write-first RAM with 1-cycle read latency.
  logic [31:0] ram [0:255];
  logic [31:0] ram_merged;
  always_comb begin
    ram_merged = ram[ram_addr[7:0]];
    for (int b = 0; b < 4; b++) begin
      if (ram_wr_strobe[b]) ram_merged[b*8 +: 8] = ram_data_in[b*8 +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (ram_wr_en) begin
      ram[ram_addr[7:0]] <= ram_merged;
      ram_data_out       <= ram_merged;
    end else begin
      ram_data_out       <= ram[ram_addr[7:0]];
    end
  end

  function automatic req_t rd(input logic [15:0] a);
    rd = '{req: 1'b1, we: 1'b0, strobe: 4'hF, addr: a, wdata: 32'h0};
  endfunction
  function automatic req_t wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    wr = '{req: 1'b1, we: 1'b1, strobe: s, addr: a, wdata: d};
  endfunction
  function automatic req_t idle();
    idle = '{req: 1'b0, we: 1'b0, strobe: 4'h0, addr: 16'h0, wdata: 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply requests, check returns due now, check grant and RAM mux.
  task automatic step(input req_t c, input req_t h, input logic lock,
                      input logic ec, input logic eh, input string tag);
    sb_t         e;
    req_t        g;
    logic [31:0] w;
    c_req = c.req; c_we = c.we; c_strobe = c.strobe; c_addr = c.addr; c_wdata = c.wdata;
    h_req = h.req; h_we = h.we; h_strobe = h.strobe; h_addr = h.addr; h_wdata = h.wdata;
    h_lock = lock;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "/c_rvalid"}, {31'd0, c_rvalid}, {31'd0, ~e.owner});
      chk({tag, "/h_rvalid"}, {31'd0, h_rvalid}, {31'd0, e.owner});
      chk({tag, "/rdata"}, e.owner ? h_rdata : c_rdata, e.data);
    end else begin
      chk({tag, "/rvalid_idle"}, {30'd0, c_rvalid, h_rvalid}, 32'd0);
    end
    chk({tag, "/gnt"}, {30'd0, c_gnt, h_gnt}, {30'd0, ec, eh});
    if (ec || eh) begin
      g = ec ? c : h;
      chk({tag, "/ram_addr"}, {16'd0, ram_addr}, {16'd0, g.addr});
      chk({tag, "/ram_wr_en"}, {31'd0, ram_wr_en}, {31'd0, g.we});
      if (g.we) begin
        chk({tag, "/ram_strobe"}, {28'd0, ram_wr_strobe}, {28'd0, g.strobe});
        w = ref_mem[g.addr[7:0]];
        for (int b = 0; b < 4; b++) if (g.strobe[b]) w[b*8 +: 8] = g.wdata[b*8 +: 8];
        ref_mem[g.addr[7:0]] = w;
      end else begin
        sb.push_back('{owner: eh, data: ref_mem[g.addr[7:0]]});
      end
    end else begin
      chk({tag, "/ram_wr_en_idle"}, {31'd0, ram_wr_en}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    reset_n = 1'b0;
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "rst0");
    step(wr(16'h4, 32'h1, 4'hF), rd(16'h8), 1'b0, 1'b0, 1'b0, "rst_req");
    chk("rst/c_rdata", c_rdata, 32'h0);
    chk("rst/h_rdata", h_rdata, 32'h0);
    reset_n = 1'b1;

    // Preload through the host port.
    step(idle(), wr(16'h4,  32'hDEADBEEF, 4'hF), 1'b0, 1'b0, 1'b1, "pre4");
    step(idle(), wr(16'h8,  32'hCAFEF00D, 4'hF), 1'b0, 1'b0, 1'b1, "pre8");
    step(idle(), wr(16'h10, 32'hA5A5A5A5, 4'hF), 1'b0, 1'b0, 1'b1, "pre10");

    // Core-only read.
    step(rd(16'h4), idle(), 1'b0, 1'b1, 1'b0, "core_rd");
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "core_ret");
    chk("core_ret/value", c_rdata, 32'hDEADBEEF);

    // Partial host write, read back, and read-after-write on the next cycle.
    step(idle(), wr(16'h10, 32'h12345678, 4'b0011), 1'b0, 1'b0, 1'b1, "hpart");
    step(idle(), rd(16'h10), 1'b0, 1'b0, 1'b1, "hpart_rd");
    step(idle(), wr(16'hC, 32'h11223344, 4'hF), 1'b0, 1'b0, 1'b1, "raw_wr");
    chk("hpart/value", h_rdata, 32'hA5A55678);
    step(idle(), rd(16'hC), 1'b0, 1'b0, 1'b1, "raw_rd");
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "raw_ret");
    chk("raw/value", h_rdata, 32'h11223344);

    // Host lock: 8 host grants, then the core, then the host again.
    for (int i = 0; i < 8; i++) step(rd(16'h4), rd(16'h8), 1'b1, 1'b0, 1'b1, "lock_h");
    step(rd(16'h4), rd(16'h8), 1'b1, 1'b1, 1'b0, "lock_c");
    step(rd(16'h4), rd(16'h8), 1'b1, 1'b0, 1'b1, "lock_h2");
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "lock_drain");

    // Reset while a host read is outstanding.
    step(idle(), rd(16'h8), 1'b0, 1'b0, 1'b1, "rmr_gnt");
    reset_n = 1'b0;
    sb.delete();
    step(rd(16'h4), rd(16'h8), 1'b0, 1'b0, 1'b0, "rmr_rst");
    reset_n = 1'b1;
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "rmr_post");

    // First conflict after reset goes to core, then strict alternation.
    step(rd(16'h4), rd(16'h8), 1'b0, 1'b1, 1'b0, "alt_c1");
    step(rd(16'h4), rd(16'h8), 1'b0, 1'b0, 1'b1, "alt_h1");
    step(rd(16'h10), rd(16'hC), 1'b0, 1'b1, 1'b0, "alt_c2");
    step(rd(16'h10), rd(16'hC), 1'b0, 1'b0, 1'b1, "alt_h2");
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "alt_drain");

    // Statistics from a fresh reset.
    reset_n = 1'b0;
    sb.delete();
    step(idle(), idle(), 1'b0, 1'b0, 1'b0, "st_rst");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++)
      step(wr(16'h20, 32'h1, 4'hF), wr(16'h24, 32'h2, 4'hF), 1'b0, (i % 2) == 0, (i % 2) == 1, "st_conf");
    for (int i = 0; i < 3; i++)
      step(wr(16'h20, 32'h3, 4'hF), idle(), 1'b0, 1'b1, 1'b0, "st_core");
`ifdef ARB_STATS_EN
    chk("stat_conflicts", {16'd0, stat_conflicts}, 32'd10);
    chk("stat_c_grants", {16'd0, stat_c_grants}, 32'd8);
    chk("stat_h_grants", {16'd0, stat_h_grants}, 32'd5);
    c_req = 1'b1; h_req = 1'b1; h_lock = 1'b0;
    repeat (65526) @(posedge clk);
    #1;
    chk("stat_conflicts_wrap", {16'd0, stat_conflicts}, 32'd0);
`else
    chk("stat_off", {stat_c_grants, stat_h_grants}, 32'd0);
    chk("stat_off_conf", {16'd0, stat_conflicts}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
